// File: rtl/lut_pipe_mapper.sv
// lut_pipe_mapper: two-stage iteration-count to RGB mapper with a runtime
// palette and a sequential step calculator for the linear colour ramp.
module lut_pipe_mapper #(
    parameter int ITERATIONS_WIDTH = 32,
    parameter int RGB_SIZE         = 24,
    parameter int NUM_ENGINES      = 12,
    parameter int LUT_SIZE         = 256,
    localparam int LUT_AW          = $clog2(LUT_SIZE)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [ITERATIONS_WIDTH-1:0]             cfg_max_iter,
    input  logic [1:0]                              cfg_mode,
    input  logic                                    cfg_load,
    output logic                                    busy,
    input  logic                                    pal_we,
    input  logic [LUT_AW-1:0]                       pal_addr,
    input  logic [RGB_SIZE-1:0]                     pal_wdata,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_ENGINES*ITERATIONS_WIDTH-1:0] in_iter,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [NUM_ENGINES*RGB_SIZE-1:0]         out_rgb
);

    localparam int IW = ITERATIONS_WIDTH;
    localparam int SW = LUT_AW + 1;
    localparam int PW = IW + SW;
    localparam int RW = IW + 2;
    localparam int GW = (LUT_AW > 8) ? LUT_AW : 8;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_CALC
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic [IW-1:0]         max_q, max_d;
    logic [1:0]            mode_q, mode_d;
    logic [SW-1:0]         step_q, step_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic signed [RW-1:0]  rem_q, rem_d;
    logic signed [RW-1:0]  div_w, rem_sub;

    logic                   s1_valid_q, s1_valid_d;
    logic [1:0]             s1_mode_q, s1_mode_d;
    logic [LUT_AW-1:0]      s1_idx_q [NUM_ENGINES];
    logic [LUT_AW-1:0]      s1_idx_d [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] s1_inside_q, s1_inside_d;

    logic                            s2_valid_q, s2_valid_d;
    logic [NUM_ENGINES*RGB_SIZE-1:0] out_rgb_q, out_rgb_d;

    logic [RGB_SIZE-1:0]    pal_q [LUT_SIZE];

    logic                            en;
    logic                            accept;
    logic [LUT_AW-1:0]               idx_w [NUM_ENGINES];
    logic [NUM_ENGINES-1:0]          inside_w;
    logic [NUM_ENGINES*RGB_SIZE-1:0] pix_w;

    assign en        = !s2_valid_q || out_ready;
    assign in_ready  = en && (state_q == S_RUN) && rst_n;
    assign accept    = in_valid && in_ready;
    assign busy      = busy_q;
    assign out_valid = s2_valid_q;
    assign out_rgb   = out_rgb_q;

    // A zero max-iteration still needs a non-zero divisor for the step search.
    assign div_w   = (max_q == '0) ? RW'(1) : {2'b00, max_q};
    assign rem_sub = rem_q - div_w;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        mode_d  = mode_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_RUN: begin
                if (cfg_load) begin
                    max_d  = cfg_max_iter;
                    mode_d = cfg_mode;
                    rem_d  = RW'(LUT_SIZE);
                    cnt_d  = '0;
                    if (s1_valid_q || s2_valid_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + SW'(1);
                rem_d = rem_sub;
                if (rem_sub[RW-1] || (rem_sub == '0)) begin
                    step_d  = cnt_d;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
        busy_d = (state_d != S_RUN);
    end

    for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_s1
        logic [IW-1:0]     it;
        logic [PW-1:0]     prod;
        logic [LUT_AW-1:0] lin;

        assign it   = in_iter[k*IW +: IW];
        assign prod = PW'(it) * PW'(step_q);
        assign lin  = (prod > PW'(LUT_SIZE - 1)) ?
                      LUT_AW'(LUT_SIZE - 1) : prod[LUT_AW-1:0];
        assign idx_w[k]    = (mode_q == 2'd1) ? it[LUT_AW-1:0] : lin;
        assign inside_w[k] = (it >= max_q);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mode_d   = s1_mode_q;
        s1_idx_d    = s1_idx_q;
        s1_inside_d = s1_inside_q;
        if (en) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_mode_d   = mode_q;
                s1_idx_d    = idx_w;
                s1_inside_d = inside_w;
            end
        end
    end

    for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_s2
        logic [GW-1:0]       gx;
        logic [7:0]          g;
        logic [RGB_SIZE-1:0] pix;

        // Left-align the index so its top 8 bits form the grey level.
        assign gx = GW'(s1_idx_q[k]) << (GW - LUT_AW);
        assign g  = gx[GW-1 -: 8];

        always_comb begin
            pix = pal_q[s1_idx_q[k]];
            if (s1_mode_q == 2'd2) begin
                pix = s1_inside_q[k] ? '0 : RGB_SIZE'({g, g, g});
            end else if (s1_inside_q[k]) begin
                pix = pal_q[LUT_SIZE-1];
            end
        end

        assign pix_w[k*RGB_SIZE +: RGB_SIZE] = pix;
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_rgb_d  = out_rgb_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_rgb_d = pix_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b0;
            max_q       <= IW'(LUT_SIZE);
            mode_q      <= 2'd0;
            step_q      <= SW'(1);
            cnt_q       <= '0;
            rem_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 2'd0;
            s1_idx_q    <= '{default: '0};
            s1_inside_q <= '0;
            s2_valid_q  <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            max_q       <= max_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_idx_q    <= s1_idx_d;
            s1_inside_q <= s1_inside_d;
            s2_valid_q  <= s2_valid_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

endmodule

// File: tb/tb_lut_pipe_mapper.sv
// tb_lut_pipe_mapper: directed checks of the colour mapper pipeline,
// config FSM, palette writes and reset behaviour.
module tb_lut_pipe_mapper;

    localparam int IW   = 32;
    localparam int RGBW = 24;
    localparam int NE   = 12;
    localparam int LS   = 256;
    localparam int AW   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [IW-1:0]      cfg_max_iter;
    logic [1:0]         cfg_mode;
    logic               cfg_load;
    logic               busy;
    logic               pal_we;
    logic [AW-1:0]      pal_addr;
    logic [RGBW-1:0]    pal_wdata;
    logic               in_valid;
    logic               in_ready;
    logic [NE*IW-1:0]   in_iter;
    logic               out_valid;
    logic               out_ready;
    logic [NE*RGBW-1:0] out_rgb;

    int total = 0;
    int bad   = 0;

    logic [RGBW-1:0]    pal_m [LS];
    logic [NE*RGBW-1:0] exp_q [$];

    always #5 clk = ~clk;

    lut_pipe_mapper #(
        .ITERATIONS_WIDTH(IW),
        .RGB_SIZE(RGBW),
        .NUM_ENGINES(NE),
        .LUT_SIZE(LS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_max_iter(cfg_max_iter),
        .cfg_mode(cfg_mode),
        .cfg_load(cfg_load),
        .busy(busy),
        .pal_we(pal_we),
        .pal_addr(pal_addr),
        .pal_wdata(pal_wdata),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_iter(in_iter),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rgb(out_rgb)
    );

    function automatic logic [NE*IW-1:0] mk_in(
        input logic [IW-1:0] a, input logic [IW-1:0] b,
        input logic [IW-1:0] c, input logic [IW-1:0] d);
        logic [NE*IW-1:0] v;
        for (int k = 0; k < NE; k++) begin
            case (k % 4)
                0: v[k*IW +: IW] = a;
                1: v[k*IW +: IW] = b;
                2: v[k*IW +: IW] = c;
                default: v[k*IW +: IW] = d;
            endcase
        end
        return v;
    endfunction

    function automatic logic [NE*RGBW-1:0] mk_rgb(
        input logic [RGBW-1:0] a, input logic [RGBW-1:0] b,
        input logic [RGBW-1:0] c, input logic [RGBW-1:0] d);
        logic [NE*RGBW-1:0] v;
        for (int k = 0; k < NE; k++) begin
            case (k % 4)
                0: v[k*RGBW +: RGBW] = a;
                1: v[k*RGBW +: RGBW] = b;
                2: v[k*RGBW +: RGBW] = c;
                default: v[k*RGBW +: RGBW] = d;
            endcase
        end
        return v;
    endfunction

    function automatic logic [NE*RGBW-1:0] exp_wrap(input logic [NE*IW-1:0] v);
        logic [NE*RGBW-1:0] r;
        logic [IW-1:0]      it;
        for (int k = 0; k < NE; k++) begin
            it = v[k*IW +: IW];
            r[k*RGBW +: RGBW] = (it >= 32'd1000) ? pal_m[255] : pal_m[it[7:0]];
        end
        return r;
    endfunction

    task automatic beat(input logic [NE*IW-1:0] iv,
                        input logic [NE*RGBW-1:0] exp, input string nm);
        int n;
        @(negedge clk);
        in_iter  = iv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: got %b want 1", nm, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_early: out_valid got %b want 0", nm, out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_rgb !== exp) begin
            bad++;
            $display("FAIL %s: valid=%b rgb=%h want rgb=%h", nm, out_valid, out_rgb, exp);
        end
    endtask

    task automatic cfg(input logic [IW-1:0] m, input logic [1:0] md,
                       input int exp_busy, input string nm);
        int n;
        @(negedge clk);
        cfg_max_iter = m;
        cfg_mode     = md;
        cfg_load     = 1'b1;
        @(posedge clk);
        #1 cfg_load = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != exp_busy) begin
            bad++;
            $display("FAIL %s_busy: got %0d cycles want %0d", nm, n, exp_busy);
        end
    endtask

    task automatic load_palette();
        logic [7:0] b;
        for (int i = 0; i < LS; i++) begin
            b = 8'(i);
            @(negedge clk);
            pal_we    = 1'b1;
            pal_addr  = b;
            pal_wdata = {b, ~b, b ^ 8'h5A};
            pal_m[i]  = {b, ~b, b ^ 8'h5A};
        end
        @(negedge clk);
        pal_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        cfg_max_iter = '0;
        cfg_mode     = 2'd0;
        cfg_load     = 1'b0;
        pal_we       = 1'b0;
        pal_addr     = '0;
        pal_wdata    = '0;
        in_valid     = 1'b0;
        in_iter      = '0;
        out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: ov=%b ir=%b busy=%b want 0 0 0",
                     out_valid, in_ready, busy);
        end
        total++;
        if (out_rgb !== '0) begin
            bad++;
            $display("FAIL reset_rgb: got %h want 0", out_rgb);
        end
        rst_n = 1'b1;
        load_palette();
    endtask

    task automatic test_default();
        beat(mk_in(10, 10, 10, 10),
             mk_rgb(pal_m[10], pal_m[10], pal_m[10], pal_m[10]), "dflt_10");
        beat(mk_in(256, 10, 255, 0),
             mk_rgb(pal_m[255], pal_m[10], pal_m[255], pal_m[0]), "dflt_mix");
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL dflt_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_linear();
        cfg(64, 2'd0, 4, "lin64");
        beat(mk_in(10, 63, 64, 1000),
             mk_rgb(pal_m[40], pal_m[252], pal_m[255], pal_m[255]), "lin64_mix");
        cfg(0, 2'd0, 256, "max0");
        beat(mk_in(0, 1, 7, 100),
             mk_rgb(pal_m[255], pal_m[255], pal_m[255], pal_m[255]), "max0_mix");
        cfg(1000, 2'd0, 1, "max1000");
        beat(mk_in(300, 999, 1000, 200),
             mk_rgb(pal_m[255], pal_m[255], pal_m[255], pal_m[200]), "max1000_mix");
    endtask

    task automatic test_modes();
        cfg(1000, 2'd1, 1, "wrap");
        beat(mk_in(300, 1000, 255, 999),
             mk_rgb(pal_m[44], pal_m[255], pal_m[255], pal_m[231]), "wrap_mix");
        cfg(64, 2'd2, 4, "grey");
        beat(mk_in(10, 64, 0, 63),
             mk_rgb(24'h282828, 24'h000000, 24'h000000, 24'hFCFCFC), "grey_mix");
        cfg(64, 2'd3, 4, "mode3");
        beat(mk_in(10, 63, 64, 1),
             mk_rgb(pal_m[40], pal_m[252], pal_m[255], pal_m[4]), "mode3_mix");
    endtask

    task automatic test_back_to_back();
        int pi, ci, g, g2, viol;
        logic fire, stall, busy_seen, cfg_sent;
        logic [NE*IW-1:0]   cur;
        logic [NE*RGBW-1:0] held, e;
        cfg(1000, 2'd1, 1, "stream_cfg");
        pi = 0; ci = 0; g = 0; g2 = 0; viol = 0;
        fire = 1'b0; stall = 1'b0; busy_seen = 1'b0; cfg_sent = 1'b0;
        held = '0; cur = '0;
        fork
            begin
                while (pi < 500 && g < 20000) begin
                    @(posedge clk);
                    #1;
                    g++;
                    cfg_load = 1'b0;
                    if (fire) begin
                        exp_q.push_back(exp_wrap(cur));
                        pi++;
                        in_valid = 1'b0;
                    end
                    if (pi == 250 && !cfg_sent) begin
                        cfg_max_iter = 1000;
                        cfg_mode     = 2'd1;
                        cfg_load     = 1'b1;
                        cfg_sent     = 1'b1;
                    end
                    if (!in_valid && pi < 500 && $urandom_range(0, 3) != 0) begin
                        for (int k = 0; k < NE; k++) begin
                            cur[k*IW +: IW] = IW'($urandom_range(0, 1100));
                        end
                        in_iter  = cur;
                        in_valid = 1'b1;
                    end
                    @(negedge clk);
                    fire = in_valid && in_ready;
                    if (busy) busy_seen = 1'b1;
                    if (busy && in_ready) viol++;
                end
                in_valid = 1'b0;
                cfg_load = 1'b0;
            end
            begin
                while (ci < 500 && g2 < 20000) begin
                    @(posedge clk);
                    #1;
                    g2++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (stall) begin
                        total++;
                        if (out_valid !== 1'b1 || out_rgb !== held) begin
                            bad++;
                            $display("FAIL stall_hold: valid=%b rgb=%h want rgb=%h",
                                     out_valid, out_rgb, held);
                        end
                    end
                    if (out_valid && out_ready) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL stream_extra: beat %0d got %h want none",
                                     ci, out_rgb);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_rgb !== e) begin
                                bad++;
                                $display("FAIL stream_beat: beat %0d got %h want %h",
                                         ci, out_rgb, e);
                            end
                        end
                        ci++;
                    end
                    stall = out_valid && !out_ready;
                    held  = out_rgb;
                end
            end
        join
        out_ready = 1'b1;
        total++;
        if (ci != 500 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stream_count: got %0d beats left %0d want 500 left 0",
                     ci, exp_q.size());
        end
        total++;
        if (busy_seen !== 1'b1 || viol != 0) begin
            bad++;
            $display("FAIL stream_drain: busy_seen=%b accepts_while_busy=%0d want 1 0",
                     busy_seen, viol);
        end
    endtask

    task automatic test_pal_write();
        logic [RGBW-1:0] old;
        old = pal_m[40];
        @(negedge clk);
        in_iter  = mk_in(40, 40, 40, 40);
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL palw_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        pal_we    = 1'b1;
        pal_addr  = 8'd40;
        pal_wdata = 24'hFF0000;
        @(posedge clk);
        #1 pal_we = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_rgb !== mk_rgb(old, old, old, old)) begin
            bad++;
            $display("FAIL palw_old: valid=%b rgb=%h want rgb=%h",
                     out_valid, out_rgb, mk_rgb(old, old, old, old));
        end
        pal_m[40] = 24'hFF0000;
        beat(mk_in(40, 40, 40, 40),
             mk_rgb(24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000), "palw_new");
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_iter  = mk_in(5, 5, 5, 5);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mrst_setup: out_valid got %b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_rgb !== '0) begin
            bad++;
            $display("FAIL mrst_drop: valid=%b rgb=%h want 0 0", out_valid, out_rgb);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mrst_ctl: ir=%b busy=%b want 0 0", in_ready, busy);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mrst_flush: out_valid got %b want 0", out_valid);
        end
        beat(mk_in(10, 256, 0, 255),
             mk_rgb(pal_m[10], pal_m[255], pal_m[0], pal_m[255]), "mrst_cfg");
    endtask

    initial begin
        test_reset();
        test_default();
        test_linear();
        test_modes();
        test_back_to_back();
        test_pal_write();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
